pipe_ctrl: RTL and testbench

- Pipeline control block that consumes the load-use `stall` from the hazard detector, the taken-branch redirect from EX, and instruction-memory readiness.
- Owns the IF/ID pipeline register (instruction, PC, valid) and generates PC-write enable, branch-select and the ID/EX bubble.
- Implements HLT handling: stop fetch, drain the pipeline, raise a sticky `halted`.
- Sits between fetch, the hazard detector and the ID/EX register in the 16-bit, 16-register pipeline.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/if_id_reg.sv | 19 +
 rtl/pipe_ctrl.sv | 85 ++++++++
 tb/tb_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 16-bit, 16-register pipeline.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0] HLT_OP = 4'hF;
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with async active-low reset, hold and squash-to-reset-value.
module if_id_reg #(
    parameter int W = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_squash,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    assign o_q = r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= RST_VAL;
        else if (i_squash) r_q <= RST_VAL;
        else if (!i_hold) r_q <= i_d;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: owns IF/ID, drives PC write/branch select/ID-EX bubble, and drains the pipe on HLT.
module pipe_ctrl import cpu_pkg::*; #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] fetch_instr,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              pc_write,
    output logic              pc_sel_branch,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              id_ex_bubble,
    output logic              halted
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_halted;
    logic             w_hlt;
    logic             w_hold;
    logic             w_squash;
    assign w_hlt = if_id_valid && (if_id_instr[OP_HI:OP_LO] == HLT_OP);
    assign halted = r_halted;
    always_comb begin
        pc_write = 1'b0;
        pc_sel_branch = 1'b0;
        id_ex_bubble = 1'b0;
        w_hold = 1'b1;
        w_squash = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (branch_taken) begin
                pc_write = 1'b1;
                pc_sel_branch = 1'b1;
                id_ex_bubble = 1'b1;
                w_squash = 1'b1;
            end else if (stall) begin
                id_ex_bubble = 1'b1;
            end else if (w_hlt || !imem_ready) begin
                w_squash = 1'b1;
            end else begin
                pc_write = 1'b1;
                w_hold = 1'b0;
            end
        end else begin
            id_ex_bubble = 1'b1;
        end
    end
    if_id_reg #(
        .W      (2 * DATA_W + 1),
        .RST_VAL({1'b0, {DATA_W{1'b0}}, NOP_INSTR})
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (w_hold),
        .i_squash(w_squash),
        .i_d     ({1'b1, fetch_pc, fetch_instr}),
        .o_q     ({if_id_valid, if_id_pc, if_id_instr})
    );
    // HLT itself proceeds to EX; the counter covers EX, MEM and WB behind it.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt <= '0;
            r_halted <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (!branch_taken && !stall && w_hlt) begin
                r_state <= ST_DRAIN;
                r_cnt <= CNT_W'(DRAIN_CYCLES - 1);
            end
        end else if (r_state == ST_DRAIN) begin
            if (r_cnt == '0) begin
                r_state <= ST_HALTED;
                r_halted <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized self-checking bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import cpu_pkg::*;
    localparam int DRAIN = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic branch_taken = 1'b0;
    logic imem_ready = 1'b0;
    logic [15:0] fetch_instr = 16'h0;
    logic [15:0] fetch_pc = 16'h0;
    logic pc_write, pc_sel_branch, id_ex_bubble, halted, if_id_valid;
    logic [15:0] if_id_instr, if_id_pc;
    int errors = 0;
    int checks = 0;
    logic [15:0] m_instr, m_pc;
    logic m_valid, m_halted;
    int m_left;
    logic [2:0] e_comb, g_comb;

    always #5 clk = ~clk;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .pc_write(pc_write), .pc_sel_branch(pc_sel_branch), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
        .halted(halted)
    );

    task automatic model_reset();
        m_instr = NOP_INSTR;
        m_pc = 16'h0;
        m_valid = 1'b0;
        m_halted = 1'b0;
        m_left = 0;
    endtask

    function automatic logic m_is_hlt();
        return m_valid && (m_instr >> 12) == 16'hF;
    endfunction

    // Expected {pc_write, pc_sel_branch, id_ex_bubble} for this cycle
    function automatic logic [2:0] model_comb(input logic br, input logic st, input logic rdy);
        if (m_halted || m_left > 0) return 3'b001;
        if (br) return 3'b111;
        if (st) return 3'b001;
        if (m_is_hlt() || !rdy) return 3'b000;
        return 3'b100;
    endfunction

    task automatic model_step(input logic br, input logic st, input logic rdy,
                              input logic [15:0] ins, input logic [15:0] pc);
        if (m_halted) begin
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_halted = 1'b1;
        end else if (br || (!st && (m_is_hlt() || !rdy))) begin
            if (!br && m_is_hlt()) m_left = DRAIN;
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = ins;
            m_pc = pc;
            m_valid = 1'b1;
        end
    endtask

    task automatic cyc(input logic br, input logic st, input logic rdy,
                       input logic [15:0] ins, input logic [15:0] pc);
        branch_taken = br;
        stall = st;
        imem_ready = rdy;
        fetch_instr = ins;
        fetch_pc = pc;
        #1;
        g_comb = {pc_write, pc_sel_branch, id_ex_bubble};
        e_comb = model_comb(br, st, rdy);
        @(posedge clk);
        #1;
        model_step(br, st, rdy, ins, pc);
    endtask

    function automatic logic [15:0] rnd_instr();
        return {4'($urandom_range(0, 14)), 12'($urandom)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pc_write, pc_sel_branch, id_ex_bubble} !== 3'b100) begin
            errors++;
            $display("FAIL reset_comb got=%b exp=100", {pc_write, pc_sel_branch, id_ex_bubble});
        end
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, halted} !== {NOP_INSTR, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_regs got=%h/%h/%b/%b exp=0000/0000/0/0", if_id_instr, if_id_pc, if_id_valid, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        cyc(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0002);
        checks++;
        if (g_comb !== 3'b100) begin
            errors++;
            $display("FAIL fetch_comb got=%b exp=100", g_comb);
        end
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid} !== {16'h1234, 16'h0002, 1'b1}) begin
            errors++;
            $display("FAIL fetch_first got=%h/%h/%b exp=1234/0002/1", if_id_instr, if_id_pc, if_id_valid);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== e_comb) begin
                errors++;
                $display("FAIL fetch_rand_comb cyc=%0d got=%b exp=%b", i, g_comb, e_comb);
            end
            checks++;
            if ({if_id_instr, if_id_valid, halted} !== {m_instr, m_valid, m_halted} || (m_valid && if_id_pc !== m_pc)) begin
                errors++;
                $display("FAIL fetch_rand_regs cyc=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, if_id_instr, if_id_pc, if_id_valid, halted, m_instr, m_pc, m_valid, m_halted);
            end
        end
    endtask

    task automatic test_stall();
        cyc(1'b0, 1'b0, 1'b1, 16'h8123, 16'h0004);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b1, rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== 3'b001 || g_comb !== e_comb) begin
                errors++;
                $display("FAIL stall_comb cyc=%0d got=%b exp=001", i, g_comb);
            end
            checks++;
            if ({if_id_instr, if_id_pc, if_id_valid} !== {16'h8123, 16'h0004, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h/%h/%b exp=8123/0004/1", i, if_id_instr, if_id_pc, if_id_valid);
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h2222, 16'h0008);
        checks++;
        if (g_comb !== 3'b100 || {if_id_instr, if_id_pc, if_id_valid} !== {16'h2222, 16'h0008, 1'b1}) begin
            errors++;
            $display("FAIL stall_release got=%b %h/%h/%b exp=100 2222/0008/1", g_comb, if_id_instr, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_branch();
        cyc(1'b1, 1'b1, 1'b1, rnd_instr(), 16'($urandom));
        checks++;
        if (g_comb !== 3'b111) begin
            errors++;
            $display("FAIL branch_comb got=%b exp=111", g_comb);
        end
        checks++;
        if ({if_id_instr, if_id_valid} !== {NOP_INSTR, 1'b0}) begin
            errors++;
            $display("FAIL branch_squash got=%h/%b exp=0000/0", if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_hlt_branch();
        cyc(1'b0, 1'b0, 1'b1, 16'hF000, 16'h000A);
        cyc(1'b1, 1'b0, 1'b1, rnd_instr(), 16'($urandom));
        checks++;
        if (g_comb !== 3'b111 || {if_id_instr, if_id_valid} !== {NOP_INSTR, 1'b0}) begin
            errors++;
            $display("FAIL hlt_branch_squash got=%b %h/%b exp=111 0000/0", g_comb, if_id_instr, if_id_valid);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h3333, 16'h0020);
        checks++;
        if (g_comb !== 3'b100 || {if_id_instr, if_id_pc, if_id_valid, halted} !== {16'h3333, 16'h0020, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hlt_branch_resume got=%b %h/%h/%b/%b exp=100 3333/0020/1/0", g_comb, if_id_instr, if_id_pc, if_id_valid, halted);
        end
    endtask

    task automatic test_imem();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== 3'b000 || {if_id_instr, if_id_valid} !== {NOP_INSTR, 1'b0}) begin
                errors++;
                $display("FAIL imem_bubble cyc=%0d got=%b %h/%b exp=000 0000/0", i, g_comb, if_id_instr, if_id_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 4) != 0), rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== e_comb) begin
                errors++;
                $display("FAIL rand_comb cyc=%0d got=%b exp=%b", i, g_comb, e_comb);
            end
            checks++;
            if ({if_id_instr, if_id_valid, halted} !== {m_instr, m_valid, m_halted} || (m_valid && if_id_pc !== m_pc)) begin
                errors++;
                $display("FAIL rand_regs cyc=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, if_id_instr, if_id_pc, if_id_valid, halted, m_instr, m_pc, m_valid, m_halted);
            end
        end
    endtask

    task automatic test_halt();
        cyc(1'b0, 1'b0, 1'b1, 16'hF000, 16'h0030);
        cyc(1'b0, 1'b0, 1'b1, rnd_instr(), 16'($urandom));
        checks++;
        if (g_comb !== 3'b000) begin
            errors++;
            $display("FAIL hlt_pass got=%b exp=000", g_comb);
        end
        for (int i = 0; i < DRAIN + 10; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== 3'b001 || g_comb !== e_comb) begin
                errors++;
                $display("FAIL halt_comb cyc=%0d got=%b exp=001", i, g_comb);
            end
            checks++;
            if ({if_id_instr, if_id_valid, halted} !== {NOP_INSTR, 1'b0, 1'(i >= DRAIN - 1)} || halted !== m_halted) begin
                errors++;
                $display("FAIL halt_state cyc=%0d got=%h/%b/%b exp=0000/0/%b", i, if_id_instr, if_id_valid, halted, i >= DRAIN - 1);
            end
        end
    endtask

    task automatic test_reset_drain();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 16'hF000, 16'h0040);
        cyc(1'b0, 1'b0, 1'b1, rnd_instr(), 16'($urandom));
        cyc(1'b0, 1'b0, 1'b1, rnd_instr(), 16'($urandom));
        checks++;
        if (g_comb !== 3'b001) begin
            errors++;
            $display("FAIL drain_before_reset got=%b exp=001", g_comb);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pc_write, pc_sel_branch, id_ex_bubble, if_id_instr, if_id_pc, if_id_valid, halted} !== {3'b100, NOP_INSTR, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_async_reset got=%b%b%b %h/%h/%b/%b exp=100 0000/0000/0/0", pc_write, pc_sel_branch, id_ex_bubble, if_id_instr, if_id_pc, if_id_valid, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, rnd_instr(), 16'($urandom));
            checks++;
            if (g_comb !== 3'b100 || {if_id_instr, if_id_pc, if_id_valid, halted} !== {m_instr, m_pc, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL post_reset_run cyc=%0d got=%b %h/%h/%b/%b exp=100 %h/%h/1/0", i, g_comb, if_id_instr, if_id_pc, if_id_valid, halted, m_instr, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_hlt_branch();
        test_imem();
        test_random();
        test_halt();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
